// File: rtl/axis_switch_event_source.sv
// Switch event source: two-flop synchroniser, debouncer, 4-bit event FIFO
// presented on an AXI-Stream master port as {4'b0000, switches} bytes.
module axis_switch_event_source #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned FIFO_AWIDTH     = 2
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [3:0] sw,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic [3:0] stable_sw,
    output logic       overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AWIDTH;
    localparam int unsigned CNT_W = 24;
    localparam int unsigned INC_W = CNT_W + 1;
    localparam int unsigned CW    = FIFO_AWIDTH + 1;

    logic [3:0]             s1_q, s1_d;
    logic [3:0]             s2_q, s2_d;
    logic [3:0]             cand_q, cand_d;
    logic [3:0]             stable_q, stable_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       cnt_base;
    logic [INC_W-1:0]       cnt_inc;
    logic                   wr_ev;

    logic [3:0]             mem_q [DEPTH];
    logic [3:0]             mem_d [DEPTH];
    logic [FIFO_AWIDTH-1:0] wptr_q, wptr_d;
    logic [FIFO_AWIDTH-1:0] rptr_q, rptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   ovf_q, ovf_d;
    logic                   fifo_rd, fifo_wr, fifo_full;

    // Synchroniser and debouncer; the first cycle of a new level already counts.
    always_comb begin
        s1_d     = sw;
        s2_d     = s1_q;
        cand_d   = s2_q;
        stable_d = stable_q;
        cnt_d    = '0;
        wr_ev    = 1'b0;
        cnt_base = (s2_q != cand_q) ? '0 : cnt_q;
        cnt_inc  = {1'b0, cnt_base} + INC_W'(1);
        if (s2_q != stable_q) begin
            if (cnt_inc == INC_W'(DEBOUNCE_CYCLES)) begin
                stable_d = s2_q;
                wr_ev    = 1'b1;
            end else begin
                cnt_d = CNT_W'(cnt_inc);
            end
        end
    end

    // FIFO bookkeeping; a full FIFO still accepts a write when a read frees a slot.
    always_comb begin
        mem_d     = mem_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        fifo_full = (count_q == CW'(DEPTH));
        fifo_rd   = (count_q != '0) && m_axis_tready;
        fifo_wr   = wr_ev && (!fifo_full || fifo_rd);
        ovf_d     = ovf_q | (wr_ev && fifo_full && !fifo_rd);
        if (fifo_wr) begin
            mem_d[wptr_q] = s2_q;
            wptr_d        = wptr_q + FIFO_AWIDTH'(1);
        end
        if (fifo_rd) begin
            rptr_d = rptr_q + FIFO_AWIDTH'(1);
        end
        case ({fifo_wr, fifo_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers, all cleared by the asynchronous reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign m_axis_tvalid = (count_q != '0);
    assign m_axis_tdata  = {4'b0000, mem_q[rptr_q]};
    assign stable_sw     = stable_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_axis_switch_event_source.sv
// Directed bench for axis_switch_event_source with DEBOUNCE_CYCLES=4.
module tb_axis_switch_event_source;

    logic       aclk;
    logic       aresetn;
    logic [3:0] sw;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [7:0] m_axis_tdata;
    logic [3:0] stable_sw;
    logic       overflow;

    int         total;
    int         passed;
    logic [7:0] got [$];

    axis_switch_event_source #(
        .DEBOUNCE_CYCLES(4),
        .FIFO_AWIDTH    (2)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .sw           (sw),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .stable_sw    (stable_sw),
        .overflow     (overflow)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Record each byte that will handshake at the coming rising edge.
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) got.push_back(m_axis_tdata);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] gq(input int i);
        return (i < got.size()) ? got[i] : 8'hEE;
    endfunction

    initial begin
        total         = 0;
        passed        = 0;
        aresetn       = 1'b0;
        sw            = 4'h0;
        m_axis_tready = 1'b1;

        // Reset
        tick(3);
        chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        aresetn = 1'b1;
        tick(1);
        chk("rst_tdata", 32'(m_axis_tdata), 32'h00);
        chk("rst_stable", 32'(stable_sw), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        got.delete();
        tick(20);
        chk("rst_no_bytes", 32'(got.size()), 32'd0);

        // Single change: edge N is the first tick after setting sw
        sw = 4'h5;
        tick(5);
        chk("single_stable_n4", 32'(stable_sw), 32'h0);
        chk("single_tvalid_n4", 32'(m_axis_tvalid), 32'd0);
        tick(1);
        chk("single_stable_n5", 32'(stable_sw), 32'h5);
        chk("single_tvalid_n5", 32'(m_axis_tvalid), 32'd1);
        chk("single_tdata_n5", 32'(m_axis_tdata), 32'h05);
        tick(1);
        chk("single_tvalid_n6", 32'(m_axis_tvalid), 32'd0);

        // Return to 0 emits one 00 byte
        got.delete();
        sw = 4'h0;
        tick(10);
        chk("zero_count", 32'(got.size()), 32'd1);
        chk("zero_byte", 32'(gq(0)), 32'h00);
        chk("zero_stable", 32'(stable_sw), 32'h0);

        // Glitch rejection
        got.delete();
        sw = 4'h1;
        tick(3);
        sw = 4'h0;
        tick(10);
        chk("glitch_stable", 32'(stable_sw), 32'h0);
        chk("glitch_count", 32'(got.size()), 32'd0);

        // Bouncing then hold
        sw = 4'h1; tick(2);
        sw = 4'h0; tick(2);
        sw = 4'h1; tick(2);
        sw = 4'h0; tick(2);
        chk("bounce_none_yet", 32'(got.size()), 32'd0);
        sw = 4'h1;
        tick(12);
        chk("bounce_count", 32'(got.size()), 32'd1);
        chk("bounce_byte", 32'(gq(0)), 32'h01);
        chk("bounce_stable", 32'(stable_sw), 32'h1);

        // Backpressure: first return to 0, then queue 1,2,3
        sw = 4'h0;
        tick(8);
        got.delete();
        m_axis_tready = 1'b0;
        sw = 4'h1; tick(8);
        chk("bp_tvalid_1", 32'(m_axis_tvalid), 32'd1);
        chk("bp_tdata_1", 32'(m_axis_tdata), 32'h01);
        sw = 4'h2; tick(8);
        chk("bp_tdata_2", 32'(m_axis_tdata), 32'h01);
        sw = 4'h3; tick(8);
        chk("bp_tdata_3", 32'(m_axis_tdata), 32'h01);
        chk("bp_stable", 32'(stable_sw), 32'h3);
        m_axis_tready = 1'b1;
        tick(3);
        chk("bp_drained", 32'(m_axis_tvalid), 32'd0);
        chk("bp_count", 32'(got.size()), 32'd3);
        chk("bp_b0", 32'(gq(0)), 32'h01);
        chk("bp_b1", 32'(gq(1)), 32'h02);
        chk("bp_b2", 32'(gq(2)), 32'h03);

        // Overflow: five events into a four-deep FIFO
        got.delete();
        m_axis_tready = 1'b0;
        sw = 4'h1; tick(8);
        sw = 4'h2; tick(8);
        sw = 4'h3; tick(8);
        sw = 4'h4; tick(8);
        chk("ovf_before", 32'(overflow), 32'd0);
        sw = 4'h5; tick(8);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_stable", 32'(stable_sw), 32'h5);
        chk("ovf_head", 32'(m_axis_tdata), 32'h01);
        m_axis_tready = 1'b1;
        tick(4);
        chk("ovf_drained", 32'(m_axis_tvalid), 32'd0);
        chk("ovf_count", 32'(got.size()), 32'd4);
        chk("ovf_b0", 32'(gq(0)), 32'h01);
        chk("ovf_b1", 32'(gq(1)), 32'h02);
        chk("ovf_b2", 32'(gq(2)), 32'h03);
        chk("ovf_b3", 32'(gq(3)), 32'h04);

        // Refill to full, then write at the same edge as a read
        got.delete();
        m_axis_tready = 1'b0;
        sw = 4'h1; tick(8);
        sw = 4'h2; tick(8);
        sw = 4'h3; tick(8);
        sw = 4'h4; tick(8);
        sw = 4'h6;
        tick(5);
        chk("rw_stable_pre", 32'(stable_sw), 32'h4);
        m_axis_tready = 1'b1;
        tick(1);
        chk("rw_stable_post", 32'(stable_sw), 32'h6);
        chk("rw_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("rw_head", 32'(m_axis_tdata), 32'h02);
        tick(8);
        chk("rw_drained", 32'(m_axis_tvalid), 32'd0);
        chk("rw_overflow", 32'(overflow), 32'd1);
        chk("rw_count", 32'(got.size()), 32'd5);
        chk("rw_b0", 32'(gq(0)), 32'h01);
        chk("rw_b3", 32'(gq(3)), 32'h04);
        chk("rw_b4", 32'(gq(4)), 32'h06);

        // Reset mid-stream with three bytes queued
        m_axis_tready = 1'b0;
        sw = 4'h1; tick(8);
        sw = 4'h2; tick(8);
        sw = 4'h3; tick(8);
        chk("mid_tvalid_pre", 32'(m_axis_tvalid), 32'd1);
        @(posedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("mid_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("mid_overflow", 32'(overflow), 32'd0);
        chk("mid_stable", 32'(stable_sw), 32'h0);
        chk("mid_tdata", 32'(m_axis_tdata), 32'h00);
        sw = 4'h0;
        tick(2);
        aresetn = 1'b1;
        m_axis_tready = 1'b1;
        got.delete();
        tick(20);
        chk("mid_no_stale", 32'(got.size()), 32'd0);
        sw = 4'h3;
        tick(8);
        chk("mid_new_count", 32'(got.size()), 32'd1);
        chk("mid_new_byte", 32'(gq(0)), 32'h03);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/axis_switch_event_source.md
Name: axis_switch_event_source

Overview:
- Upstream AXI-Stream byte source for the demo board's switch-driven state path.
- Synchronises and debounces four slide switches and emits one byte per debounced change into a 4-entry FIFO.
- Presents the FIFO head on a master AXI-Stream port. Bytes are {4'b0000, switches}, so a downstream boolean consumer sees "any switch on".

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive cycles a new synchronised switch value must hold before it is accepted; legal range 1..2^24-1.
- FIFO_AWIDTH, 2, log2 of FIFO depth; default depth 4.

Ports:
- aclk  input  1  stream and logic clock.
- aresetn  input  1  reset, asynchronous assert, active-low.
- sw  input  4  raw asynchronous slide-switch levels.
- m_axis_tvalid  output  1  FIFO non-empty.
- m_axis_tready  input  1  downstream accepts the byte this cycle.
- m_axis_tdata  output  8  FIFO head byte, {4'b0000, debounced switch value}.
- stable_sw  output  4  current debounced switch value.
- overflow  output  1  sticky flag: at least one event dropped because the FIFO was full.

Behaviour:
- Reset (aresetn=0, asynchronous): clears every register.
  - Registers cleared: sync stages, candidate value, counter, stable_sw, FIFO pointers and count, overflow.
  - Outputs then read: m_axis_tvalid=0, m_axis_tdata=8'h00, stable_sw=4'h0, overflow=0.
  - Reset asserted mid-operation discards FIFO contents and any in-progress debounce count.
  - No byte is emitted for the post-reset switch value unless it differs from 4'h0.
- Synchroniser: two flops, sw -> s1 -> s2. Their contents are not visible at the ports.
- Debounce counter:
  - Clears when s2 == stable_sw, or when s2 differs from the value it had on the previous cycle.
  - Otherwise it increments.
  - When the increment would reach DEBOUNCE_CYCLES: stable_sw <= s2, counter clears, and a write event is generated in the same cycle.
- Debounce latency: if edge N is the first to capture a new level in s1 and sw holds, stable_sw updates at edge N+DEBOUNCE_CYCLES+1.
- Glitches: a level held fewer than DEBOUNCE_CYCLES cycles at s2 produces no change and no byte.
- Bouncing: bouncing between two non-stable values restarts the count on every change.
- FIFO: synchronous, depth 2^FIFO_AWIDTH, pointers wrap modulo depth, count register of FIFO_AWIDTH+1 bits.
  - Write: on a write event when count < depth, or when count == depth and a read occurs in the same cycle.
  - Read: when m_axis_tvalid && m_axis_tready.
  - Simultaneous read and write at any fill level leaves count unchanged; data order is preserved.
  - Empty read is impossible because tvalid=0.
- Overflow: a write event with count == depth and no same-cycle read drops the byte and sets overflow=1 at that edge. overflow holds until reset. stable_sw still updates.
- AXI-Stream rules:
  - m_axis_tvalid = (count != 0), registered-state-derived with no combinational path from m_axis_tready.
  - m_axis_tdata = memory at the read pointer; it holds stable while tvalid && !tready.
  - tvalid never drops without a handshake except on reset.
- Stream latency: a byte written at edge E is visible with tvalid=1 immediately after E when the FIFO was empty.
- Back-to-back: transfers at one byte per cycle when tready stays high.
- Bits [7:4] of tdata are always 0.

Test Plan:
- Common setup: DEBOUNCE_CYCLES=4, FIFO_AWIDTH=2, tready=1 unless stated.
- Reset: hold aresetn=0 for 3 cycles, then release with sw=4'h0 → tvalid=0, tdata=8'h00, stable_sw=0, overflow=0, and no byte for 20 cycles.
- Single change: sw 0→4'h5 with edge N first capturing it → stable_sw=5 and tvalid=1 with tdata=8'h05 after edge N+5; tvalid=0 after the next edge.
- Glitch rejection: sw=4'h1 for 3 cycles then back to 0 → stable_sw stays 0 and no tvalid. Bouncing 1,0,1,0 each lasting 2 cycles, then holding 1 → exactly one byte 8'h01, after the final hold.
- Backpressure: tready=0, produce changes to 1,2,3 → tvalid=1 and tdata=8'h01 held constant. Raise tready → bytes 01,02,03 delivered in consecutive cycles, then tvalid=0.
- Overflow and full-boundary: tready=0, produce 5 changes 1,2,3,4,5 → the 5th is dropped, overflow=1, stable_sw=5. Draining yields 01,02,03,04. Refill to 4 entries, then force a write in the same cycle as a read → no drop, overflow unchanged, order preserved.
- Reset mid-stream: 3 bytes queued with tready=0, assert aresetn=0 asynchronously between edges → tvalid drops at once and overflow=0. After release, no stale bytes are emitted.
